// File: rtl/execute_unit.sv
// X-stage execute datapath: combinational ALU/compare/branch adder plus iterative signed mul/div.
// Latency: ALU and branch_target 0 cycles; mul/div result and one-cycle rdy pulse 33 edges after the start edge.
// Backpressure: starts are ignored while busy; a start in the DONE cycle is taken. EXEC_DIV_EN builds the divider.
module execute_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [4:0]  alu_op,
    input  logic [4:0]  shamt,
    output logic [31:0] alu_result,
    output logic        is_not_equal,
    output logic        is_less_than,
    output logic        alu_overflow,
    input  logic [31:0] pc_plus_1,
    input  logic [16:0] imm,
    output logic [31:0] branch_target,
    input  logic        ctrl_mul,
    input  logic        ctrl_div,
    output logic [31:0] multdiv_result,
    output logic        multdiv_exception,
    output logic        multdiv_rdy,
    output logic        multdiv_busy
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    logic [31:0] sum, diff;
    assign sum  = operand_a + operand_b;
    assign diff = operand_a - operand_b;

    always_comb begin
        alu_result   = 32'd0;
        alu_overflow = 1'b0;
        case (alu_op)
            5'b00000: begin
                alu_result   = sum;
                alu_overflow = (operand_a[31] == operand_b[31]) && (sum[31] != operand_a[31]);
            end
            5'b00001: begin
                alu_result   = diff;
                alu_overflow = (operand_a[31] != operand_b[31]) && (diff[31] != operand_a[31]);
            end
            5'b00010: alu_result = operand_a & operand_b;
            5'b00011: alu_result = operand_a | operand_b;
            5'b00100: alu_result = operand_a << shamt;
            5'b00101: alu_result = $signed(operand_a) >>> shamt;
            default:  alu_result = 32'd0;
        endcase
    end

    assign is_not_equal  = operand_a != operand_b;
    assign is_less_than  = $signed(operand_a) < $signed(operand_b);
    assign branch_target = pc_plus_1 + {{15{imm[16]}}, imm};

    // Iterative unit: works on magnitudes, sign applied once in the final RUN cycle.
    state_t      state, state_nxt;
    logic        start, fin, is_div, neg;
    logic [4:0]  cnt;
    logic [32:0] hi;
    logic [31:0] lo, opnd, a_abs, b_abs;
    logic [32:0] mul_sum;
    logic [63:0] mag, prod;

    assign start   = (ctrl_mul || ctrl_div) && (state != S_RUN);
    assign a_abs   = operand_a[31] ? (~operand_a + 32'd1) : operand_a;
    assign b_abs   = operand_b[31] ? (~operand_b + 32'd1) : operand_b;
    assign mul_sum = hi + {1'b0, (lo[0] ? opnd : 32'd0)};
    assign mag     = {hi[31:0], lo};
    assign prod    = neg ? (~mag + 64'd1) : mag;

`ifdef EXEC_DIV_EN
    logic        div_zero, div_ovf, div_ge;
    logic [32:0] div_shift, div_diff;
    logic [31:0] quo;
    assign div_shift = {hi[31:0], lo[31]};
    assign div_ge    = div_shift >= {1'b0, opnd};
    assign div_diff  = div_shift - {1'b0, opnd};
    assign quo       = neg ? (~lo + 32'd1) : lo;
`endif

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (fin) state_nxt = S_DONE;
            S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign multdiv_busy = (state == S_RUN);
    assign multdiv_rdy  = (state == S_DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt               <= 5'd0;
            fin               <= 1'b0;
            is_div            <= 1'b0;
            neg               <= 1'b0;
            hi                <= 33'd0;
            lo                <= 32'd0;
            opnd              <= 32'd0;
            multdiv_result    <= 32'd0;
            multdiv_exception <= 1'b0;
`ifdef EXEC_DIV_EN
            div_zero          <= 1'b0;
            div_ovf           <= 1'b0;
`endif
        end else if (start) begin
            cnt    <= 5'd0;
            fin    <= 1'b0;
            is_div <= !ctrl_mul;
            neg    <= operand_a[31] ^ operand_b[31];
            hi     <= 33'd0;
            lo     <= ctrl_mul ? b_abs : a_abs;
            opnd   <= ctrl_mul ? a_abs : b_abs;
`ifdef EXEC_DIV_EN
            div_zero <= (operand_b == 32'd0);
            div_ovf  <= (operand_a == 32'h8000_0000) && (operand_b == 32'hFFFF_FFFF);
`endif
        end else if (state == S_RUN) begin
            if (!fin) begin
                cnt <= cnt + 5'd1;
                fin <= (cnt == 5'd31);
                if (!is_div) begin
                    hi <= {1'b0, mul_sum[32:1]};
                    lo <= {mul_sum[0], lo[31:1]};
                end
`ifdef EXEC_DIV_EN
                else if (div_ge) begin
                    hi <= div_diff;
                    lo <= {lo[30:0], 1'b1};
                end else begin
                    hi <= div_shift;
                    lo <= {lo[30:0], 1'b0};
                end
`endif
            end else if (!is_div) begin
                multdiv_result    <= prod[31:0];
                multdiv_exception <= prod[63:32] != {32{prod[31]}};
            end else begin
`ifdef EXEC_DIV_EN
                multdiv_result    <= div_zero ? 32'd0 : quo;
                multdiv_exception <= div_zero || div_ovf;
`else
                multdiv_result    <= 32'd0;
                multdiv_exception <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_execute_unit.sv
// Bench for execute_unit: directed and randomized ALU, branch, mul/div handshake and reset cases.
module tb_execute_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] operand_a = '0, operand_b = '0, pc_plus_1 = '0;
    logic [4:0]  alu_op = '0, shamt = '0;
    logic [16:0] imm = '0;
    logic        ctrl_mul = 1'b0, ctrl_div = 1'b0;
    logic [31:0] alu_result, branch_target, multdiv_result;
    logic        is_not_equal, is_less_than, alu_overflow;
    logic        multdiv_exception, multdiv_rdy, multdiv_busy;

    int compared = 0;
    int mismatched = 0;

    execute_unit dut (
        .clock(clock), .reset(reset),
        .operand_a(operand_a), .operand_b(operand_b),
        .alu_op(alu_op), .shamt(shamt),
        .alu_result(alu_result), .is_not_equal(is_not_equal),
        .is_less_than(is_less_than), .alu_overflow(alu_overflow),
        .pc_plus_1(pc_plus_1), .imm(imm), .branch_target(branch_target),
        .ctrl_mul(ctrl_mul), .ctrl_div(ctrl_div),
        .multdiv_result(multdiv_result), .multdiv_exception(multdiv_exception),
        .multdiv_rdy(multdiv_rdy), .multdiv_busy(multdiv_busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference ALU from signed integer arithmetic.
    task automatic alu_case(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] sh);
        longint sa, sb, s;
        logic [31:0] er;
        logic eo;
        alu_op = op; operand_a = a; operand_b = b; shamt = sh;
        #1;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s  = 0; er = '0; eo = 1'b0;
        case (op)
            5'd0: begin s = sa + sb; er = s[31:0]; eo = (s != longint'($signed(er))); end
            5'd1: begin s = sa - sb; er = s[31:0]; eo = (s != longint'($signed(er))); end
            5'd2: er = a & b;
            5'd3: er = a | b;
            5'd4: er = a << sh;
            5'd5: er = $signed(a) >>> sh;
            default: er = '0;
        endcase
        chk($sformatf("alu_result op%0d", op), alu_result, er);
        chk($sformatf("alu_overflow op%0d", op), alu_overflow, eo);
        chk("is_not_equal", is_not_equal, a != b);
        chk("is_less_than", is_less_than, sa < sb);
    endtask

    task automatic br_case(input logic [31:0] pc, input logic [16:0] im);
        longint t;
        pc_plus_1 = pc; imm = im;
        #1;
        t = longint'(pc) + longint'($signed(im));
        chk("branch_target", branch_target, t[31:0]);
    endtask

    function automatic void md_model(input bit mul, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r, output logic e);
        longint p;
        int q;
        if (mul) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[31:0];
            e = (p != longint'($signed(r)));
        end else begin
`ifdef EXEC_DIV_EN
            if (b == 32'd0) begin
                r = 32'd0; e = 1'b1;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                r = 32'h8000_0000; e = 1'b1;
            end else begin
                q = $signed(a) / $signed(b);
                r = q; e = 1'b0;
            end
`else
            r = 32'd0; e = 1'b1;
`endif
        end
    endfunction

    // Called just after a negedge; returns half a cycle after the start edge with operands scrambled.
    task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
        ctrl_mul = m; ctrl_div = d; operand_a = a; operand_b = b;
        @(negedge clock);
        ctrl_mul = 1'b0; ctrl_div = 1'b0;
        operand_a = $urandom; operand_b = $urandom;
    endtask

    task automatic wait_done(input string tag, input logic [31:0] er, input logic ee,
                             input bit inject, input bit chain);
        int cyc = 0;
        chk({tag, " busy_at_start"}, multdiv_busy, 1'b1);
        while (!multdiv_rdy && cyc < 60) begin
            if (inject && cyc == 10) begin
                ctrl_mul = 1'b1;
                operand_a = $urandom; operand_b = $urandom;
            end
            @(negedge clock);
            ctrl_mul = 1'b0;
            cyc++;
        end
        chk({tag, " latency"}, cyc, 33);
        chk({tag, " result"}, multdiv_result, er);
        chk({tag, " exception"}, multdiv_exception, ee);
        chk({tag, " busy_at_done"}, multdiv_busy, 1'b0);
        if (!chain) begin
            @(negedge clock);
            chk({tag, " rdy_one_cycle"}, multdiv_rdy, 1'b0);
            chk({tag, " result_held"}, multdiv_result, er);
        end
    endtask

    task automatic run_op(input string tag, input bit m, input bit d,
                          input logic [31:0] a, input logic [31:0] b, input bit inject);
        logic [31:0] er;
        logic ee;
        md_model(m, a, b, er, ee);
        start_op(m, d, a, b);
        wait_done(tag, er, ee, inject, 1'b0);
    endtask

    initial begin
        logic [31:0] er, ra, rb;
        logic ee;
        int seen;
        bit m;

        repeat (2) @(negedge clock);
        chk("reset busy", multdiv_busy, 1'b0);
        chk("reset rdy", multdiv_rdy, 1'b0);
        chk("reset result", multdiv_result, 32'd0);
        chk("reset exception", multdiv_exception, 1'b0);
        reset = 1'b0;

        // Directed ALU and branch vectors
        @(negedge clock);
        alu_case(5'd0, 32'h7FFF_FFFF, 32'd1, 5'd0);
        chk("add_max literal", alu_result, 32'h8000_0000);
        chk("add_max ovf literal", alu_overflow, 1'b1);
        alu_case(5'd1, 32'd5, 32'd7, 5'd0);
        chk("sub literal", alu_result, 32'hFFFF_FFFE);
        chk("sub lt literal", is_less_than, 1'b1);
        alu_case(5'd5, 32'h8000_0001, 32'd0, 5'd4);
        chk("sra literal", alu_result, 32'hF800_0000);
        alu_case(5'd4, 32'h8000_0001, 32'd0, 5'd4);
        chk("sll literal", alu_result, 32'h0000_0010);
        alu_case(5'd1, 32'h8000_0000, 32'd1, 5'd0);
        alu_case(5'd6, 32'h1234_5678, 32'h1, 5'd3);
        alu_case(5'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
        br_case(32'h0000_0010, 17'h1FFFE);
        chk("branch literal", branch_target, 32'h0000_000E);
        br_case(32'hFFFF_FFFF, 17'h0FFFF);

        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            ra = $urandom;
            rb = (i % 5 == 0) ? ra : $urandom;
            alu_case(5'($urandom_range(0, 9)), ra, rb, 5'($urandom));
            br_case($urandom, 17'($urandom));
        end
        @(negedge clock);
        alu_op = '0;

        // Multiply / divide directed
        run_op("mul neg", 1'b1, 1'b0, 32'hFFFF_FFFD, 32'd7, 1'b0);
        chk("mul neg literal", multdiv_result, 32'hFFFF_FFEB);
        run_op("mul ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b0);
        run_op("div neg", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);
        run_op("div zero", 1'b0, 1'b1, 32'd1234, 32'd0, 1'b0);
        run_op("div ovf", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("mul wins", 1'b1, 1'b1, 32'd100, 32'hFFFF_FFF0, 1'b0);
        run_op("mul ignore", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1);

        // Start accepted in the DONE cycle
        md_model(1'b1, 32'd12345, 32'd678, er, ee);
        start_op(1'b1, 1'b0, 32'd12345, 32'd678);
        wait_done("chain first", er, ee, 1'b0, 1'b1);
        md_model(1'b0, 32'hFFFF_0000, 32'd3, er, ee);
        start_op(1'b0, 1'b1, 32'hFFFF_0000, 32'd3);
        wait_done("chain second", er, ee, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            m  = 1'($urandom);
            ra = (i % 4 == 0) ? 32'($signed(16'($urandom))) : $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            run_op($sformatf("rand%0d", i), m, !m, ra, rb, i % 2 == 1);
        end

        // Reset mid-operation aborts with no completion
        start_op(1'b1, 1'b0, 32'd9, 32'd9);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("abort busy", multdiv_busy, 1'b0);
        chk("abort rdy", multdiv_rdy, 1'b0);
        chk("abort result", multdiv_result, 32'd0);
        chk("abort exception", multdiv_exception, 1'b0);
        ctrl_mul = 1'b1;
        @(negedge clock);
        ctrl_mul = 1'b0;
        chk("reset beats start", multdiv_busy, 1'b0);
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (multdiv_rdy) seen++;
        end
        chk("abort no rdy", seen, 0);
        run_op("after reset", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
